// File: rtl/psum_output_packer.sv
// Packs four per-kernel psum streams into one {kn3,kn2,kn1,kn0} word.
// Each lane is buffered in a small FIFO so skewed arrivals still pair up.
`default_nettype none

module psum_lane #(
  parameter int BIT_WIDTH  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_clear,
  input  logic                 i_val,
  input  logic [BIT_WIDTH-1:0] i_psum,
  input  logic                 i_pop,
  output logic [BIT_WIDTH-1:0] o_head,
  output logic                 o_empty,
  output logic                 o_full,
  output logic                 o_ovf
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [BIT_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [BIT_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]          occ_q, occ_d;
  logic                 full_q, full_d;
  logic                 push;

  // A full lane may still take a push when it is popped the same cycle.
  assign push    = i_val & (~full_q | i_pop);
  assign o_ovf   = i_val & full_q & ~i_pop;
  assign o_head  = mem_q[rd_ptr_q];
  assign o_empty = (occ_q == '0);
  assign o_full  = full_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push) begin
      mem_d[wr_ptr_q] = i_psum;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (i_pop) rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !i_pop)      occ_d = occ_q + (AW+1)'(1);
    else if (!push && i_pop) occ_d = occ_q - (AW+1)'(1);
    if (i_clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end
    full_d = (occ_d == (AW+1)'(FIFO_DEPTH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      full_q   <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      full_q   <= full_d;
    end
  end
endmodule

module psum_output_packer #(
  parameter int BIT_WIDTH  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int REG_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_clear,
  input  logic [BIT_WIDTH-1:0]   i_psum_kn0,
  input  logic                   i_psum_kn0_val,
  input  logic [BIT_WIDTH-1:0]   i_psum_kn1,
  input  logic                   i_psum_kn1_val,
  input  logic [BIT_WIDTH-1:0]   i_psum_kn2,
  input  logic                   i_psum_kn2_val,
  input  logic [BIT_WIDTH-1:0]   i_psum_kn3,
  input  logic                   i_psum_kn3_val,
  output logic [4*BIT_WIDTH-1:0] o_word,
  output logic                   o_word_val,
  input  logic                   i_word_rdy,
  output logic [3:0]             o_lane_full,
  output logic                   o_ovf_err,
  output logic [REG_WIDTH-1:0]   o_word_cnt
);
  localparam int NUM_LANES = 4;

  logic [NUM_LANES-1:0][BIT_WIDTH-1:0] psum_in, head;
  logic [NUM_LANES-1:0]                val_in, empty, full, ovf;
  logic                                load_en;

  logic [4*BIT_WIDTH-1:0] word_q, word_d;
  logic                   word_val_q, word_val_d;
  logic                   ovf_q, ovf_d;
  logic [REG_WIDTH-1:0]   cnt_q, cnt_d;

  assign psum_in = {i_psum_kn3, i_psum_kn2, i_psum_kn1, i_psum_kn0};
  assign val_in  = {i_psum_kn3_val, i_psum_kn2_val, i_psum_kn1_val, i_psum_kn0_val};

  // Pop depends only on registered state and rdy, never on this cycle's pushes.
  assign load_en = ~|empty & (~word_val_q | i_word_rdy);

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    psum_lane #(.BIT_WIDTH(BIT_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_lane (
      .clk    (clk),
      .rst    (rst),
      .i_clear(i_clear),
      .i_val  (val_in[k]),
      .i_psum (psum_in[k]),
      .i_pop  (load_en & ~i_clear),
      .o_head (head[k]),
      .o_empty(empty[k]),
      .o_full (full[k]),
      .o_ovf  (ovf[k])
    );
  end

  always_comb begin
    word_d     = word_q;
    word_val_d = word_val_q;
    ovf_d      = ovf_q | (|ovf);
    cnt_d      = cnt_q;
    if (word_val_q && i_word_rdy) cnt_d = cnt_q + REG_WIDTH'(1);
    if (load_en) begin
      word_d     = head;
      word_val_d = 1'b1;
    end else if (word_val_q && i_word_rdy) begin
      word_val_d = 1'b0;
    end
    if (i_clear) begin
      word_d     = '0;
      word_val_d = 1'b0;
      ovf_d      = 1'b0;
      cnt_d      = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q     <= '0;
      word_val_q <= 1'b0;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      word_q     <= word_d;
      word_val_q <= word_val_d;
      ovf_q      <= ovf_d;
      cnt_q      <= cnt_d;
    end
  end

  assign o_word      = word_q;
  assign o_word_val  = word_val_q;
  assign o_lane_full = full;
  assign o_ovf_err   = ovf_q;
  assign o_word_cnt  = cnt_q;
endmodule

`default_nettype wire

// File: tb/tb_psum_output_packer.sv
// Random and directed stimulus against a queue-based reference model of the packer.
module tb_psum_output_packer;
  localparam int DEPTH = 4;

  logic clk = 1'b0, rst = 1'b1, i_clear = 1'b0, i_word_rdy = 1'b0;
  logic [3:0][7:0] psum = '0;
  logic [3:0]      pval = '0;

  logic [31:0] o_word, w4_word;
  logic        o_word_val, w4_val, o_ovf_err, w4_ovf;
  logic [3:0]  o_lane_full, w4_full;
  logic [31:0] o_word_cnt;
  logic [3:0]  w4_cnt;

  psum_output_packer #(.BIT_WIDTH(8), .FIFO_DEPTH(DEPTH), .REG_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .i_clear(i_clear),
    .i_psum_kn0(psum[0]), .i_psum_kn0_val(pval[0]),
    .i_psum_kn1(psum[1]), .i_psum_kn1_val(pval[1]),
    .i_psum_kn2(psum[2]), .i_psum_kn2_val(pval[2]),
    .i_psum_kn3(psum[3]), .i_psum_kn3_val(pval[3]),
    .o_word(o_word), .o_word_val(o_word_val), .i_word_rdy(i_word_rdy),
    .o_lane_full(o_lane_full), .o_ovf_err(o_ovf_err), .o_word_cnt(o_word_cnt)
  );

  psum_output_packer #(.BIT_WIDTH(8), .FIFO_DEPTH(DEPTH), .REG_WIDTH(4)) dut_w4 (
    .clk(clk), .rst(rst), .i_clear(i_clear),
    .i_psum_kn0(psum[0]), .i_psum_kn0_val(pval[0]),
    .i_psum_kn1(psum[1]), .i_psum_kn1_val(pval[1]),
    .i_psum_kn2(psum[2]), .i_psum_kn2_val(pval[2]),
    .i_psum_kn3(psum[3]), .i_psum_kn3_val(pval[3]),
    .o_word(w4_word), .o_word_val(w4_val), .i_word_rdy(i_word_rdy),
    .o_lane_full(w4_full), .o_ovf_err(w4_ovf), .o_word_cnt(w4_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
  endtask

  // Reference model: one queue per kernel plus the output register.
  logic [7:0]  mq[4][$];
  logic [31:0] m_word;
  logic        m_val, m_ovf;
  int unsigned m_cnt;

  task automatic m_reset();
    for (int k = 0; k < 4; k++) mq[k].delete();
    m_word = '0; m_val = 1'b0; m_ovf = 1'b0; m_cnt = 0;
  endtask

  task automatic m_edge();
    bit pop;
    bit full_pre[4];
    if (i_clear) begin m_reset(); return; end
    pop = !m_val || i_word_rdy;
    for (int k = 0; k < 4; k++) begin
      if (mq[k].size() == 0) pop = 0;
      full_pre[k] = (mq[k].size() == DEPTH);
    end
    if (m_val && i_word_rdy) m_cnt++;
    if (pop) begin
      for (int k = 0; k < 4; k++) m_word[8*k +: 8] = mq[k].pop_front();
      m_val = 1'b1;
    end else if (m_val && i_word_rdy) m_val = 1'b0;
    for (int k = 0; k < 4; k++)
      if (pval[k]) begin
        if (!full_pre[k] || pop) mq[k].push_back(psum[k]);
        else m_ovf = 1'b1;
      end
  endtask

  task automatic compare();
    logic [3:0] f;
    for (int k = 0; k < 4; k++) f[k] = (mq[k].size() == DEPTH);
    chk("word", o_word, m_word);
    chk("word_val", o_word_val, m_val);
    chk("lane_full", o_lane_full, f);
    chk("ovf_err", o_ovf_err, m_ovf);
    chk("word_cnt", o_word_cnt, m_cnt);
    chk("word_cnt_w4", w4_cnt, m_cnt % 16);
  endtask

  task automatic step();
    @(posedge clk);
    m_edge();
    #1 compare();
  endtask

  task automatic async_rst();
    #2 rst = 1'b1;
    m_reset();
    #1 compare();
    #1 rst = 1'b0;
  endtask

  task automatic send_words(input int n);
    i_word_rdy = 1'b1;
    for (int i = 0; i < n; i++) begin
      pval = 4'hF;
      for (int k = 0; k < 4; k++) psum[k] = 8'($urandom);
      step();
    end
    pval = '0;
    repeat (3) step();
  endtask

  int unsigned base;
  logic [7:0]  b;

  initial begin
    m_reset();
    #2 compare();
    #10 rst = 1'b0;
    #1 compare();

    // aligned push
    i_word_rdy = 1'b1;
    pval = 4'hF; psum = {8'h44, 8'h33, 8'h22, 8'h11};
    step();
    pval = '0;
    step();
    chk("aligned_word", o_word, 32'h44332211);
    chk("aligned_val", o_word_val, 1'b1);
    step();
    chk("aligned_val_drop", o_word_val, 1'b0);
    chk("aligned_cnt", o_word_cnt, 32'd1);

    // skewed arrivals
    for (int c = 0; c < 12; c++) begin
      pval = '0;
      if (c == 0) begin pval[0] = 1'b1; psum[0] = 8'h01; end
      if (c == 3) begin pval[1] = 1'b1; psum[1] = 8'h02; end
      if (c == 5) begin pval[2] = 1'b1; psum[2] = 8'h03; end
      if (c == 9) begin pval[3] = 1'b1; psum[3] = 8'h04; end
      step();
      if (c == 10) chk("skew_word", o_word, 32'h04030201);
      if (c < 10) chk("skew_early", o_word_val, 1'b0);
    end

    // backpressure: 5 sets into depth-4 lanes plus the output register
    base = m_cnt;
    i_word_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pval = 4'hF; b = 8'h10 + 8'(i); psum = {b, b, b, b};
      step();
    end
    pval = '0;
    step();
    chk("bp_word", o_word, 32'h10101010);
    chk("bp_full", o_lane_full, 4'hF);
    chk("bp_ovf", o_ovf_err, 1'b0);
    i_word_rdy = 1'b1;
    for (int j = 0; j < 5; j++) begin
      step();
      b = 8'h11 + 8'(j);
      if (j < 4) chk("bp_drain", o_word, {b, b, b, b});
    end
    chk("bp_cnt", o_word_cnt, base + 5);

    // overflow on lane 2
    i_word_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pval = 4'b0100; psum[2] = (i == 4) ? 8'hAA : 8'h20 + 8'(i);
      step();
    end
    pval = '0;
    step();
    chk("ovf_set", o_ovf_err, 1'b1);
    for (int i = 0; i < 4; i++) begin
      pval = 4'b1011; psum[0] = 8'h30 + 8'(i); psum[1] = 8'h40 + 8'(i); psum[3] = 8'h50 + 8'(i);
      step();
    end
    pval = '0;
    i_word_rdy = 1'b1;
    repeat (6) step();

    // clear with three lanes holding data, count = 7
    i_clear = 1'b1; step(); i_clear = 1'b0;
    send_words(7);
    pval = 4'b0111; psum = {8'h00, 8'h63, 8'h62, 8'h61};
    step();
    pval = '0;
    i_clear = 1'b1; step(); i_clear = 1'b0;
    chk("clr_cnt", o_word_cnt, 32'd0);
    chk("clr_val", o_word_val, 1'b0);
    pval = 4'b1000; psum[3] = 8'h64;
    step();
    pval = '0;
    repeat (3) step();

    // async reset with three lanes holding data
    i_clear = 1'b1; step(); i_clear = 1'b0;
    send_words(7);
    pval = 4'b1101; psum = {8'h73, 8'h72, 8'h00, 8'h71};
    step();
    pval = '0;
    async_rst();
    chk("rst_cnt", o_word_cnt, 32'd0);
    pval = 4'b0010; psum[1] = 8'h74;
    step();
    pval = '0;
    repeat (3) step();

    // 4-bit counter wrap
    i_clear = 1'b1; step(); i_clear = 1'b0;
    send_words(17);
    chk("wrap_cnt4", w4_cnt, 4'd1);
    chk("wrap_cnt32", o_word_cnt, 32'd17);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      pval       = 4'($urandom);
      psum       = 32'($urandom);
      i_word_rdy = ($urandom_range(0, 9) < 6);
      i_clear    = ($urandom_range(0, 199) == 0);
      step();
      if ($urandom_range(0, 299) == 0) async_rst();
    end
    i_clear = 1'b0; pval = '0; i_word_rdy = 1'b1;
    repeat (8) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
